cipher_out_buffer: RTL

- Output stage directly downstream of the final encryption round. Captures each 128-bit ciphertext word that the round registers, and queues it in a small FIFO.
- Presents the queued words to the system through a valid/ready handshake.
- The round pipeline has no backpressure, so words that arrive while the FIFO is full are dropped and counted.
- Includes a synchronous flush for key/mode changes.

---
 rtl/cipher_out_buffer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cipher_out_buffer.sv
// cipher_out_buffer
//   Output stage behind the final encryption round. Each ciphertext word that
//   the last round registers is queued in a small FIFO. The FIFO presents its
//   head to the system through a valid/ready handshake. The round pipeline
//   cannot be stalled, so a word that arrives while the FIFO is full is
//   dropped, and the drop is counted.
//
//   Optional feature macro: CTBUF_PARITY_EN
//     When defined, every entry also holds 16 even-parity bits, one per byte
//     of IN. These bits are presented on out_parity, aligned with OUT.
//
// Ports
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-low reset
//   IN         ciphertext from the last round's output register
//   in_valid   IN carries a new word this cycle
//   flush      synchronous clear of queue contents and drop statistics
//   OUT        registered head-of-queue word (show-ahead)
//   out_valid  OUT holds a queued word
//   out_ready  consumer takes OUT this cycle
//   full       queue holds DEPTH entries
//   level      occupancy, 0..DEPTH
//   overflow   sticky: at least one word has been dropped
//   drop_cnt   saturating count of dropped words
//   out_parity (CTBUF_PARITY_EN only) per-byte even parity of OUT

module cipher_out_buffer #(
   parameter int BLOCK_LENGTH = 128,
   parameter int DEPTH        = 4,
   parameter int CNT_W        = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [BLOCK_LENGTH-1:0]   IN,
   input  logic                      in_valid,
   input  logic                      flush,
   output logic [BLOCK_LENGTH-1:0]   OUT,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      full,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic [CNT_W-1:0]          drop_cnt
`ifdef CTBUF_PARITY_EN
   ,
   output logic [15:0]               out_parity
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [BLOCK_LENGTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr, wr_next, rd_next;
   logic [LVL_W-1:0]        level_next;
   logic [BLOCK_LENGTH-1:0] out_next;
   logic                    push, pop, drop;

   // A flush cycle ignores both sides of the queue. Qualifying push and pop
   // here keeps that rule in one place.
   assign pop  = out_valid && out_ready && !flush;
   assign push = in_valid && (!full || out_valid && out_ready) && !flush;
   assign drop = in_valid && full && !(out_valid && out_ready) && !flush;

   assign out_valid = (level != '0);
   assign full      = (level == LVL_W'(DEPTH));

   // Next head pointer and occupancy. The output register is loaded with
   // the word that will be at the head after this edge. That word is IN
   // when it is written straight into the head slot (push into an empty
   // queue, or push+pop with a single entry). When the queue drains, OUT
   // keeps the value that was popped last.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
      rd_next    = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
      wr_next    = push ? wr_ptr + PTR_W'(1) : wr_ptr;
      level_next = level;
      if (push && !pop)
         level_next = level + LVL_W'(1);
      else if (pop && !push)
         level_next = level - LVL_W'(1);
      out_next = OUT;
      if (level_next != '0) begin
         if (push && (wr_ptr == rd_next))
            out_next = IN;
         else
            out_next = mem[rd_next];
      end
   end

   // NOTE: the storage array has no reset. Every slot is written before it can be read, and leaving it out of reset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= IN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         OUT      <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         OUT      <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         wr_ptr <= wr_next;
         rd_ptr <= rd_next;
         level  <= level_next;
         OUT    <= out_next;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1)
               drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

`ifdef CTBUF_PARITY_EN
   // Parity bit k covers IN[8k+7:8k]. Even parity is the XOR of the byte.
   // This assumes BLOCK_LENGTH is 128.
   logic [15:0] par_mem [DEPTH];
   logic [15:0] in_parity;
   logic [15:0] par_next;

   always_comb begin
      in_parity = '0;
      for (int k = 0; k < 16; k++)
         in_parity[k] = ^IN[8*k +: 8];
   end

   // This selection mirrors out_next, so parity stays aligned with OUT.
   always_comb begin
      par_next = out_parity;
      if (level_next != '0) begin
         if (push && (wr_ptr == rd_next))
            par_next = in_parity;
         else
            par_next = par_mem[rd_next];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         par_mem[wr_ptr] <= in_parity;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         out_parity <= '0;
      else if (flush)
         out_parity <= '0;
      else
         out_parity <= par_next;
   end
`endif

endmodule
